id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- Pipeline register between decode (register-file read) and execute in the 5-stage MIPS pipeline.
- Captures register-file read data (readda1/readda2), immediate, register specifiers and decoded control each cycle.
- Contains load-use hazard detection. On a hazard it asserts a one-cycle stall to PC/IF-ID and inserts a bubble into EX.
- Handles branch flush and keeps saturating stall/flush event counters for debug.

Parameters:
- DW, 32, datapath width (PC, read data, immediate)
- CNT_W, 16, width of the stall and flush event counters

Ports:
- clk  input  1  pipeline clock; all state updates on posedge
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk
- id_valid  input  1  decode stage holds a real instruction
- id_pc  input  DW  PC+4 of decode instruction
- id_readda1  input  DW  register-file port 1 data (rs)
- id_readda2  input  DW  register-file port 2 data (rt)
- id_imm  input  DW  sign-extended immediate
- id_rs, id_rt, id_rd  input  5 each  register specifiers
- id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_regdst  input  1 each  decoded control
- id_aluop  input  4  ALU operation
- flush  input  1  branch/jump taken; kill decode instruction
- stall  output  1  hold PC and IF/ID this cycle (combinational)
- ex_valid  output  1  EX holds a real instruction
- ex_pc, ex_readda1, ex_readda2, ex_imm  output  DW  registered copies
- ex_rs, ex_rt  output  5  registered specifiers (for forwarding unit)
- ex_writereg  output  5  destination: id_regdst ? id_rd : id_rt, resolved at capture
- ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc  output  1 each
- ex_aluop  output  4
- stall_count, flush_count  output  CNT_W  saturating event counters

Behaviour:
- Reset (rst_n=0 at posedge): all ex_* outputs are 0, ex_valid=0, both counters 0. stall is forced to 0 while rst_n=0. Reset mid-stall discards the bubble/hazard state; no residual stall after release.
- Hazard condition is combinational:
  - haz = ex_valid & ex_memread & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (ex_rt == id_rt))
  - stall = rst_n & haz & ~flush
- Next-state priority per posedge:
  1. !rst_n → reset values.
  2. flush → bubble: ex_valid=0, all ex_ control and ex_writereg = 0; datapath fields don't-care, driven 0. flush_count += 1 (saturating).
  3. haz → bubble as above. stall_count += 1 (saturating).
  4. Otherwise load: all ex_* take id_* values; ex_valid = id_valid.
- When id_valid=0 on a load, control outputs are captured as 0 regardless of id_ control values.
- Latency: one cycle from ID inputs to ex_ outputs.
- Stall length: exactly one cycle per load-use. After the bubble ex_memread=0, so stall self-clears. The decode instruction is re-presented by upstream and loaded the next cycle.
- Back-to-back loads each generate an independent one-cycle stall when dependent.
- Register 0 never causes a hazard.
- A load whose rt matches only id_rd (not rs/rt) causes no stall.
- Simultaneous flush and haz: flush wins. stall=0, only flush_count increments.
- Counters saturate at 2^CNT_W-1 and never wrap.

Test Plan:
- Reset: assert rst_n=0 for 2 cycles with id_valid=1, id_regwrite=1 → all ex_* = 0, stall=0, counters 0.
- Pass-through: id_pc=0x40, readda1=9, readda2=4, rs=1, rt=2, rd=3, regdst=1, regwrite=1, aluop=2 → next cycle ex_readda1=9, ex_readda2=4, ex_writereg=3, ex_regwrite=1, ex_valid=1, stall=0.
- Load-use: lw with rt=5, regdst=0 enters EX; next ID has rs=5 → stall=1 that cycle; following cycle ex_valid=0, ex_memread=0, stall=0; stall_count=1; re-presented instruction appears in EX one cycle later.
- No false hazard: lw with rt=0, then ID rs=0 → stall=0. lw rt=6, ID rs=1, rt=2, rd=6 → stall=0.
- Flush vs hazard: create the load-use condition and assert flush the same cycle → stall=0, bubble in EX, flush_count=1, stall_count unchanged.
- Saturation: with CNT_W=4, force 20 consecutive flush cycles → flush_count holds at 15.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and
// saturating debug counters for stall and flush events.
module id_ex_stage #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [DW-1:0]    id_pc,
  input  logic [DW-1:0]    id_readda1,
  input  logic [DW-1:0]    id_readda2,
  input  logic [DW-1:0]    id_imm,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             id_memtoreg,
  input  logic             id_alusrc,
  input  logic             id_regdst,
  input  logic [3:0]       id_aluop,
  input  logic             flush,
  output logic             stall,
  output logic             ex_valid,
  output logic [DW-1:0]    ex_pc,
  output logic [DW-1:0]    ex_readda1,
  output logic [DW-1:0]    ex_readda2,
  output logic [DW-1:0]    ex_imm,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_writereg,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_memtoreg,
  output logic             ex_alusrc,
  output logic [3:0]       ex_aluop,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  logic             valid_q, valid_d;
  logic [DW-1:0]    pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [4:0]       rs_q, rs_d, rt_q, rt_d, wreg_q, wreg_d;
  logic             regwrite_q, regwrite_d, memread_q, memread_d;
  logic             memwrite_q, memwrite_d, memtoreg_q, memtoreg_d;
  logic             alusrc_q, alusrc_d;
  logic [3:0]       aluop_q, aluop_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             haz;

  // A load in EX whose destination feeds the decode instruction; $zero never counts.
  always_comb begin
    haz = valid_q & memread_q & (rt_q != 5'd0) & id_valid &
          ((rt_q == id_rs) | (rt_q == id_rt));
  end

  assign stall = rst_n & haz & ~flush;

  always_comb begin
    valid_d     = 1'b0;
    pc_d        = '0;
    rd1_d       = '0;
    rd2_d       = '0;
    imm_d       = '0;
    rs_d        = '0;
    rt_d        = '0;
    wreg_d      = '0;
    regwrite_d  = 1'b0;
    memread_d   = 1'b0;
    memwrite_d  = 1'b0;
    memtoreg_d  = 1'b0;
    alusrc_d    = 1'b0;
    aluop_d     = '0;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (flush) begin
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else if (haz) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      // Datapath always loads; control is qualified so an empty slot can never write.
      valid_d    = id_valid;
      pc_d       = id_pc;
      rd1_d      = id_readda1;
      rd2_d      = id_readda2;
      imm_d      = id_imm;
      rs_d       = id_rs;
      rt_d       = id_rt;
      wreg_d     = id_valid ? (id_regdst ? id_rd : id_rt) : 5'd0;
      regwrite_d = id_valid & id_regwrite;
      memread_d  = id_valid & id_memread;
      memwrite_d = id_valid & id_memwrite;
      memtoreg_d = id_valid & id_memtoreg;
      alusrc_d   = id_valid & id_alusrc;
      aluop_d    = id_valid ? id_aluop : 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      wreg_q      <= '0;
      regwrite_q  <= 1'b0;
      memread_q   <= 1'b0;
      memwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      alusrc_q    <= 1'b0;
      aluop_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      imm_q       <= imm_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      wreg_q      <= wreg_d;
      regwrite_q  <= regwrite_d;
      memread_q   <= memread_d;
      memwrite_q  <= memwrite_d;
      memtoreg_q  <= memtoreg_d;
      alusrc_q    <= alusrc_d;
      aluop_q     <= aluop_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_pc       = pc_q;
  assign ex_readda1  = rd1_q;
  assign ex_readda2  = rd2_q;
  assign ex_imm      = imm_q;
  assign ex_rs       = rs_q;
  assign ex_rt       = rt_q;
  assign ex_writereg = wreg_q;
  assign ex_regwrite = regwrite_q;
  assign ex_memread  = memread_q;
  assign ex_memwrite = memwrite_q;
  assign ex_memtoreg = memtoreg_q;
  assign ex_alusrc   = alusrc_q;
  assign ex_aluop    = aluop_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule
